rv_memory: RTL and testbench
============================

Name: rv_memory

Overview:
- Data-memory stage between execute and rv_write.
- Registers the execute-stage result.
- Runs one load/store transaction on a simple req/ack data bus, with byte-lane alignment of store data and byte enables.
- Hands the raw bus read data plus the pass-through writeback fields to rv_write, which does the load extraction and sign-extension.
- Stalls upstream while a bus transaction is outstanding.

Parameters:
- ADDR_W, 32, data bus address width (byte address; the word-aligned address is driven).

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous active-low reset
- i_valid  in  1  execute stage presents a valid instruction
- i_alu_result  in  32  effective address, or ALU result for non-memory ops
- i_store_data  in  32  rs2 value
- i_funct3  in  3  load/store size and sign
- i_mem_read  in  1  load
- i_mem_write  in  1  store
- i_reg_write  in  1  instruction writes rd
- i_rd  in  5  destination register
- i_res_src  in  res_src_t  writeback source select
- i_pc_next  in  32  pc+4
- o_stall  out  1  upstream must hold its inputs
- o_bus_req  out  1  bus request
- o_bus_write  out  1  1 = store
- o_bus_addr  out  ADDR_W  address with [1:0] forced to 0
- o_bus_wdata  out  32  lane-replicated store data
- o_bus_sel  out  4  byte enables
- i_bus_ack  in  1  transaction complete; i_bus_rdata valid for loads
- i_bus_rdata  in  32  read data
- o_alu_result, o_funct3, o_rd, o_res_src, o_pc_next  out  32/3/5/res_src_t/32  registered pass-through to rv_write
- o_reg_write  out  1  gated writeback enable
- o_data  out  32  captured i_bus_rdata
- o_fault  out  1  one-cycle pulse: misaligned access or illegal funct3

Behaviour:
- Reset (async, i_reset_n=0):
  - FSM goes to IDLE.
  - o_bus_req, o_stall, o_reg_write and o_fault go to 0 immediately.
  - All other outputs clear to 0.
- FSM states: IDLE, BUS.
- IDLE:
  - Inputs are sampled each edge while o_stall=0.
  - i_valid=0 gives a bubble: o_reg_write=0 next cycle.
  - i_valid=1, no memory op: pass-through fields registered; o_reg_write=i_reg_write next cycle (1-cycle latency).
  - i_valid=1 with i_mem_read or i_mem_write, aligned, legal: latch the fields, go to BUS; o_reg_write=0 meanwhile.
  - Misaligned access, or illegal funct3 (011, 11x, or 1xx on a store): no bus cycle; o_fault=1 for one cycle; o_reg_write=0.
- Alignment rules:
  - Half access requires addr[0]=0.
  - Word access requires addr[1:0]=00.
- Byte enables and store data:
  - Byte: o_bus_sel = 0001<<addr[1:0]; o_bus_wdata = {4{byte}}.
  - Half: o_bus_sel = addr[1] ? 1100 : 0011; o_bus_wdata = {2{half}}.
  - Word: o_bus_sel = 1111; o_bus_wdata = the full word.
  - Loads drive the same sel pattern.
- BUS:
  - o_bus_req=1 and bus fields held stable; o_stall=1.
  - On the edge where i_bus_ack=1:
    - o_data is captured (loads only; stores leave o_data unchanged).
    - Next cycle o_reg_write = latched reg_write (0 for stores).
    - FSM returns to IDLE and o_bus_req drops.
  - A load completes 1 cycle after ack: total latency 1 + bus wait cycles.
  - o_stall is combinational: (state==BUS) && !i_bus_ack. Upstream may therefore advance on the ack cycle, giving back-to-back accesses with no dead cycle.
- i_bus_ack while in IDLE is ignored.
- o_reg_write is asserted for exactly one cycle per retired instruction.
- Reset asserted mid-BUS aborts the transaction; a late ack after reset is ignored.

Decomposition:
- rv_structs package: res_src_t (existing); new enum mem_state_t {IDLE, BUS}; funct3 size constants (F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101).
- One natural sub-module: rv_mem_align. Combinational: addr[1:0] + funct3 + store data -> sel, wdata, misaligned, illegal.

Test Plan:
- SW addr 0x1004, data 0xDEADBEEF, ack after 2 waits:
  - bus_addr=0x1004, sel=1111, wdata=0xDEADBEEF.
  - o_stall high for 2 cycles, then falls on the ack cycle.
  - o_reg_write stays 0.
- LB addr 0x2003, rdata 0x80FF1234, immediate ack:
  - sel=1000.
  - One cycle after ack: o_data=0x80FF1234, o_alu_result=0x2003, o_funct3=000, o_reg_write=1.
- SH addr 0x0002, data 0x0000ABCD: sel=1100, wdata=0xABCDABCD. LH addr 0x0001: no req, o_fault pulses 1 cycle, o_reg_write=0.
- ADD result 0x55 with reg_write=1, rd=7: next cycle o_alu_result=0x55, o_rd=7, o_reg_write=1, no bus req. Back-to-back loads: req drops for 0 cycles between them.
- Reset pulled low during BUS with ack pending:
  - o_bus_req drops asynchronously.
  - Ack asserted after reset release produces no o_reg_write.
  - Next instruction processes normally.

Source files
------------

// File: rtl/rv_structs_pkg.sv
// Shared pipeline types for the rv core: writeback select, memory-stage FSM
// states, load/store funct3 encodings and the writeback field bundle.
package rv_structs;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_PC4 = 2'd2
  } res_src_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } mem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Fields carried from execute to writeback for one instruction.
  typedef struct packed {
    logic [31:0] alu_result;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    res_src_t    res_src;
    logic [31:0] pc_next;
    logic        reg_write;
    logic        is_load;
  } wb_fields_t;

endpackage

// File: rtl/rv_mem_align.sv
// Byte-lane steering for the data bus: byte enables, lane-replicated store
// data, and the misaligned / illegal-size classification of an access.
module rv_mem_align
  import rv_structs::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic        is_store,
  input  logic [31:0] store_data,
  output logic [3:0]  sel,
  output logic [31:0] wdata,
  output logic        misaligned,
  output logic        illegal
);

  // Decode access size into lanes; unsigned sizes do not exist for stores.
  always_comb begin
    sel        = '0;
    wdata      = '0;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        sel   = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      F3_H, F3_HU: begin
        sel        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{store_data[15:0]}};
        misaligned = addr_lo[0];
      end
      F3_W: begin
        sel        = 4'b1111;
        wdata      = store_data;
        misaligned = |addr_lo;
      end
      default: illegal = 1'b1;
    endcase
    if (is_store && funct3[2]) illegal = 1'b1;
  end

endmodule

// File: rtl/rv_memory.sv
// Data-memory stage: registers execute results, runs one load/store on the
// req/ack bus and hands raw read data plus writeback fields to rv_write.
module rv_memory
  import rv_structs::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_valid,
  input  logic [31:0]       i_alu_result,
  input  logic [31:0]       i_store_data,
  input  logic [2:0]        i_funct3,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic              i_reg_write,
  input  logic [4:0]        i_rd,
  input  res_src_t          i_res_src,
  input  logic [31:0]       i_pc_next,
  output logic              o_stall,
  output logic              o_bus_req,
  output logic              o_bus_write,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [31:0]       o_bus_wdata,
  output logic [3:0]        o_bus_sel,
  input  logic              i_bus_ack,
  input  logic [31:0]       i_bus_rdata,
  output logic [31:0]       o_alu_result,
  output logic [2:0]        o_funct3,
  output logic [4:0]        o_rd,
  output res_src_t          o_res_src,
  output logic [31:0]       o_pc_next,
  output logic              o_reg_write,
  output logic [31:0]       o_data,
  output logic              o_fault
);

  mem_state_t  state;
  wb_fields_t  in_f, lat;
  // lat holds a non-memory instruction that arrived on an ack cycle and must
  // wait one cycle behind the retiring bus access (one retire per cycle).
  logic        pend_vld;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic        misaligned, illegal;
  logic        is_mem, fault, accept, retire_lat;

  rv_mem_align u_align (
    .addr_lo    (i_alu_result[1:0]),
    .funct3     (i_funct3),
    .is_store   (i_mem_write),
    .store_data (i_store_data),
    .sel        (sel),
    .wdata      (wdata),
    .misaligned (misaligned),
    .illegal    (illegal)
  );

  assign in_f = '{alu_result: i_alu_result, funct3: i_funct3, rd: i_rd,
                  res_src: i_res_src, pc_next: i_pc_next,
                  reg_write: i_reg_write && !i_mem_write,
                  is_load: i_mem_read && !i_mem_write};

  // Releasing the stall on the ack cycle lets upstream advance with no bubble.
  assign o_stall    = (state == BUS) && !i_bus_ack;
  assign accept     = i_valid && !o_stall;
  assign is_mem     = i_mem_read || i_mem_write;
  assign fault      = is_mem && (misaligned || illegal);
  assign retire_lat = ((state == BUS) && i_bus_ack) || ((state == IDLE) && pend_vld);

  // Stage FSM: retire the latched instruction, then accept the incoming one.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state        <= IDLE;
      lat          <= '0;
      pend_vld     <= 1'b0;
      o_bus_req    <= 1'b0;
      o_bus_write  <= 1'b0;
      o_bus_addr   <= '0;
      o_bus_wdata  <= '0;
      o_bus_sel    <= '0;
      o_alu_result <= '0;
      o_funct3     <= '0;
      o_rd         <= '0;
      o_res_src    <= RES_ALU;
      o_pc_next    <= '0;
      o_reg_write  <= 1'b0;
      o_data       <= '0;
      o_fault      <= 1'b0;
    end else begin
      o_reg_write <= 1'b0;
      o_fault     <= 1'b0;
      if (retire_lat) begin
        o_alu_result <= lat.alu_result;
        o_funct3     <= lat.funct3;
        o_rd         <= lat.rd;
        o_res_src    <= lat.res_src;
        o_pc_next    <= lat.pc_next;
        o_reg_write  <= lat.reg_write;
        if (state == BUS && lat.is_load) o_data <= i_bus_rdata;
        pend_vld <= 1'b0;
        if (state == BUS) begin
          state     <= IDLE;
          o_bus_req <= 1'b0;
        end
      end
      if (accept) begin
        if (is_mem && !fault) begin
          lat         <= in_f;
          state       <= BUS;
          o_bus_req   <= 1'b1;
          o_bus_write <= i_mem_write;
          o_bus_addr  <= {i_alu_result[ADDR_W-1:2], 2'b00};
          o_bus_wdata <= wdata;
          o_bus_sel   <= sel;
        end else if (is_mem) begin
          o_fault <= 1'b1;
        end else if (retire_lat) begin
          lat      <= in_f;
          pend_vld <= 1'b1;
        end else begin
          o_alu_result <= i_alu_result;
          o_funct3     <= i_funct3;
          o_rd         <= i_rd;
          o_res_src    <= i_res_src;
          o_pc_next    <= i_pc_next;
          o_reg_write  <= i_reg_write;
        end
      end
    end
  end

endmodule

// File: tb/tb_rv_memory.sv
// Bench for rv_memory: directed scenarios plus a randomized stream scored
// against a lane/alignment model and an in-order retirement queue.
module tb_rv_memory;
  import rv_structs::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, mem_read, mem_write, reg_write;
  logic [31:0] alu_in, store_data, pc_in;
  logic [2:0]  f3_in;
  logic [4:0]  rd_in;
  res_src_t    res_in;
  logic        stall, bus_req, bus_write, bus_ack, reg_write_o, fault;
  logic [31:0] bus_addr, bus_wdata, bus_rdata, alu_o, pc_o, data_o;
  logic [3:0]  bus_sel;
  logic [2:0]  f3_o;
  logic [4:0]  rd_o;
  res_src_t    res_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] alu; logic [2:0] f3; logic [4:0] rd; res_src_t rs;
    logic [31:0] pc; logic ld; logic [31:0] data;
  } ret_t;
  typedef struct {
    logic [31:0] addr; logic wr; logic [3:0] sel; logic [31:0] wdata; logic [31:0] rdata;
  } bus_t;

  ret_t ret_q[$];
  bus_t bus_q[$];
  int   exp_faults = 0;
  int   seen_faults = 0;
  int   wait_left = -1;

  rv_memory #(.ADDR_W(32)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(valid), .i_alu_result(alu_in),
    .i_store_data(store_data), .i_funct3(f3_in), .i_mem_read(mem_read),
    .i_mem_write(mem_write), .i_reg_write(reg_write), .i_rd(rd_in),
    .i_res_src(res_in), .i_pc_next(pc_in), .o_stall(stall), .o_bus_req(bus_req),
    .o_bus_write(bus_write), .o_bus_addr(bus_addr), .o_bus_wdata(bus_wdata),
    .o_bus_sel(bus_sel), .i_bus_ack(bus_ack), .i_bus_rdata(bus_rdata),
    .o_alu_result(alu_o), .o_funct3(f3_o), .o_rd(rd_o), .o_res_src(res_o),
    .o_pc_next(pc_o), .o_reg_write(reg_write_o), .o_data(data_o), .o_fault(fault)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic mr, input logic mw, input logic rw,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                       input logic [4:0] rdn, input res_src_t rs, input logic [31:0] pc);
    valid = v; mem_read = mr; mem_write = mw; reg_write = rw; f3_in = f3;
    alu_in = a; store_data = sd; rd_in = rdn; res_in = rs; pc_in = pc;
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0, RES_ALU, 32'd0);
  endtask

  // Reference lane model: size in bytes from funct3, lanes as a shifted mask,
  // replication by multiplication.
  function automatic void model(input logic [2:0] f3, input logic [31:0] a, input logic st,
                                input logic [31:0] sd, output logic ok,
                                output logic [3:0] sel, output logic [31:0] wd);
    int  sz;
    bit  bad;
    bad = (f3[1:0] == 2'b11) || (f3[2] && (st || f3[1:0] == 2'b10));
    sz  = 1 << f3[1:0];
    ok  = !bad && ((int'(a[1:0]) % sz) == 0);
    sel = 4'(((1 << sz) - 1) << a[1:0]);
    if (sz == 1)      wd = {24'd0, sd[7:0]} * 32'h0101_0101;
    else if (sz == 2) wd = {16'd0, sd[15:0]} * 32'h0001_0001;
    else              wd = sd;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; bus_ack = 1'b0; bus_rdata = '0; bubble();
    @(negedge clk);
    checks++;
    if ({bus_req, stall, reg_write_o, fault} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=0000", {bus_req, stall, reg_write_o, fault});
    end
    checks++;
    if ({bus_addr, bus_wdata, bus_sel, bus_write, alu_o, f3_o, rd_o, res_o, pc_o, data_o} !== '0) begin
      errors++; $display("FAIL reset_data addr=%h alu=%h data=%h exp=0", bus_addr, alu_o, data_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_store_word();
    @(negedge clk); drive(1, 0, 1, 0, F3_W, 32'h1004, 32'hDEADBEEF, 5'd0, RES_ALU, 32'h100);
    @(negedge clk); bubble();
    checks++;
    if ({bus_req, bus_write, bus_addr, bus_sel, bus_wdata} !== {1'b1, 1'b1, 32'h1004, 4'b1111, 32'hDEADBEEF}) begin
      errors++; $display("FAIL sw_bus req=%b wr=%b addr=%h sel=%b wdata=%h exp 1 1 1004 1111 deadbeef",
                         bus_req, bus_write, bus_addr, bus_sel, bus_wdata);
    end
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL sw_stall_w1 got=%b exp=1", stall); end
    @(negedge clk);
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL sw_stall_w2 got=%b exp=1", stall); end
    @(negedge clk); bus_ack = 1'b1; #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL sw_stall_ack got=%b exp=0", stall); end
    @(negedge clk); bus_ack = 1'b0;
    checks++;
    if ({bus_req, reg_write_o} !== 2'b00) begin
      errors++; $display("FAIL sw_done req/regw got=%b exp=00", {bus_req, reg_write_o});
    end
  endtask

  task automatic test_load_byte();
    @(negedge clk); drive(1, 1, 0, 1, F3_B, 32'h2003, 32'h0, 5'd5, RES_MEM, 32'h108);
    @(negedge clk); bubble();
    checks++;
    if ({bus_req, bus_write, bus_addr, bus_sel} !== {1'b1, 1'b0, 32'h2000, 4'b1000}) begin
      errors++; $display("FAIL lb_bus req=%b wr=%b addr=%h sel=%b exp 1 0 2000 1000",
                         bus_req, bus_write, bus_addr, bus_sel);
    end
    bus_ack = 1'b1; bus_rdata = 32'h80FF1234;
    @(negedge clk); bus_ack = 1'b0;
    checks++;
    if ({data_o, alu_o, f3_o, reg_write_o, rd_o, res_o, bus_req} !==
        {32'h80FF1234, 32'h2003, 3'b000, 1'b1, 5'd5, RES_MEM, 1'b0}) begin
      errors++; $display("FAIL lb_retire data=%h alu=%h f3=%b regw=%b rd=%0d req=%b exp 80ff1234 2003 000 1 5 0",
                         data_o, alu_o, f3_o, reg_write_o, rd_o, bus_req);
    end
    @(negedge clk);
    checks++;
    if (reg_write_o !== 1'b0) begin errors++; $display("FAIL lb_one_pulse got=%b exp=0", reg_write_o); end
  endtask

  task automatic test_half_and_misaligned();
    @(negedge clk); drive(1, 0, 1, 0, F3_H, 32'h0002, 32'h0000ABCD, 5'd0, RES_ALU, 32'h0);
    @(negedge clk); bubble();
    checks++;
    if ({bus_req, bus_sel, bus_wdata} !== {1'b1, 4'b1100, 32'hABCDABCD}) begin
      errors++; $display("FAIL sh_bus req=%b sel=%b wdata=%h exp 1 1100 abcdabcd", bus_req, bus_sel, bus_wdata);
    end
    bus_ack = 1'b1;
    @(negedge clk); bus_ack = 1'b0;
    drive(1, 1, 0, 1, F3_H, 32'h0001, 32'h0, 5'd4, RES_MEM, 32'h0);
    @(negedge clk); bubble();
    checks++;
    if ({bus_req, fault, reg_write_o} !== 3'b010) begin
      errors++; $display("FAIL lh_misaligned req/fault/regw got=%b exp=010", {bus_req, fault, reg_write_o});
    end
    @(negedge clk);
    checks++;
    if ({fault, bus_req} !== 2'b00) begin
      errors++; $display("FAIL lh_fault_pulse fault/req got=%b exp=00", {fault, bus_req});
    end
  endtask

  task automatic test_alu();
    @(negedge clk); drive(1, 0, 0, 1, 3'b000, 32'h55, 32'h0, 5'd7, RES_ALU, 32'h204);
    @(negedge clk); bubble();
    checks++;
    if ({alu_o, rd_o, reg_write_o, bus_req, pc_o} !== {32'h55, 5'd7, 1'b1, 1'b0, 32'h204}) begin
      errors++; $display("FAIL alu_pass alu=%h rd=%0d regw=%b req=%b pc=%h exp 55 7 1 0 204",
                         alu_o, rd_o, reg_write_o, bus_req, pc_o);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); drive(1, 1, 0, 1, F3_W, 32'h3000, 32'h0, 5'd1, RES_MEM, 32'h300);
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 32'h11112222;
    drive(1, 1, 0, 1, F3_W, 32'h3004, 32'h0, 5'd2, RES_MEM, 32'h304);
    @(negedge clk);
    checks++;
    if ({bus_req, bus_addr, reg_write_o, data_o, alu_o, rd_o} !==
        {1'b1, 32'h3004, 1'b1, 32'h11112222, 32'h3000, 5'd1}) begin
      errors++; $display("FAIL b2b_first req=%b addr=%h regw=%b data=%h alu=%h rd=%0d exp 1 3004 1 11112222 3000 1",
                         bus_req, bus_addr, reg_write_o, data_o, alu_o, rd_o);
    end
    bus_rdata = 32'h33334444; bubble();
    @(negedge clk); bus_ack = 1'b0;
    checks++;
    if ({bus_req, reg_write_o, data_o, alu_o, rd_o} !== {1'b0, 1'b1, 32'h33334444, 32'h3004, 5'd2}) begin
      errors++; $display("FAIL b2b_second req=%b regw=%b data=%h alu=%h rd=%0d exp 0 1 33334444 3004 2",
                         bus_req, reg_write_o, data_o, alu_o, rd_o);
    end
  endtask

  task automatic test_reset_mid_bus();
    @(negedge clk); drive(1, 1, 0, 1, F3_W, 32'h4000, 32'h0, 5'd3, RES_MEM, 32'h400);
    @(negedge clk); bubble();
    checks++;
    if (bus_req !== 1'b1) begin errors++; $display("FAIL rst_bus_req got=%b exp=1", bus_req); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus_req, stall, reg_write_o} !== 3'b000) begin
      errors++; $display("FAIL rst_async req/stall/regw got=%b exp=000", {bus_req, stall, reg_write_o});
    end
    @(negedge clk); rst_n = 1'b1; bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
    @(negedge clk); bus_ack = 1'b0;
    checks++;
    if ({reg_write_o, bus_req, data_o} !== {1'b0, 1'b0, 32'h0}) begin
      errors++; $display("FAIL rst_late_ack regw=%b req=%b data=%h exp 0 0 0", reg_write_o, bus_req, data_o);
    end
    drive(1, 0, 0, 1, 3'b000, 32'h77, 32'h0, 5'd9, RES_ALU, 32'h500);
    @(negedge clk); bubble();
    checks++;
    if ({reg_write_o, alu_o, rd_o} !== {1'b1, 32'h77, 5'd9}) begin
      errors++; $display("FAIL rst_recover regw=%b alu=%h rd=%0d exp 1 77 9", reg_write_o, alu_o, rd_o);
    end
  endtask

  // Pick a random instruction, drive it, and record what it must produce.
  task automatic gen_instr();
    int          k  = int'($urandom_range(0, 9));
    logic [31:0] a  = $urandom;
    logic [31:0] sd = $urandom;
    logic [2:0]  f3 = 3'($urandom_range(0, 7));
    logic        rw = 1'($urandom_range(0, 1));
    logic [4:0]  rn = 5'($urandom_range(0, 31));
    res_src_t    rs = res_src_t'(2'($urandom_range(0, 2)));
    logic [31:0] pc = $urandom;
    logic        st, ok;
    logic [3:0]  sel;
    logic [31:0] wd;
    bus_t        b;
    ret_t        r;
    if (k == 0) begin
      bubble();
      return;
    end
    r = '{alu: a, f3: f3, rd: rn, rs: rs, pc: pc, ld: 1'b0, data: 32'h0};
    if (k <= 3) begin
      drive(1, 0, 0, rw, f3, a, sd, rn, rs, pc);
      if (rw) ret_q.push_back(r);
      return;
    end
    st = (k >= 7);
    if ($urandom_range(0, 3) != 0) f3 = st ? 3'($urandom_range(0, 2)) : (($urandom_range(0, 1) != 0) ? F3_BU : F3_HU);
    if ($urandom_range(0, 2) != 0) a[1:0] = (f3[1:0] == 2'b10) ? 2'b00 : (f3[1:0] == 2'b01 ? {a[1], 1'b0} : a[1:0]);
    r.alu = a; r.f3 = f3;
    drive(1, !st, st, rw, f3, a, sd, rn, rs, pc);
    model(f3, a, st, sd, ok, sel, wd);
    if (!ok) begin
      exp_faults++;
      return;
    end
    b = '{addr: {a[31:2], 2'b00}, wr: st, sel: sel, wdata: st ? wd : bus_wdata, rdata: $urandom};
    bus_q.push_back(b);
    if (!st && rw) begin
      r.ld = 1'b1; r.data = b.rdata;
      ret_q.push_back(r);
    end
  endtask

  task automatic rand_cycle(input bit gen);
    ret_t e;
    @(negedge clk);
    bus_ack = 1'b0;
    if (reg_write_o) begin
      checks++;
      if (ret_q.size() == 0) begin
        errors++; $display("FAIL rnd_unexpected_retire rd=%0d alu=%h exp none", rd_o, alu_o);
      end else begin
        e = ret_q.pop_front();
        if ({alu_o, f3_o, rd_o, res_o, pc_o} !== {e.alu, e.f3, e.rd, e.rs, e.pc}) begin
          errors++; $display("FAIL rnd_retire alu=%h f3=%b rd=%0d pc=%h exp alu=%h f3=%b rd=%0d pc=%h",
                             alu_o, f3_o, rd_o, pc_o, e.alu, e.f3, e.rd, e.pc);
        end
        if (e.ld && data_o !== e.data) begin
          errors++; $display("FAIL rnd_load_data got=%h exp=%h", data_o, e.data);
        end
      end
    end
    if (fault) seen_faults++;
    if (bus_req) begin
      checks++;
      if (bus_q.size() == 0) begin
        errors++; $display("FAIL rnd_unexpected_bus addr=%h exp none", bus_addr);
      end else begin
        if ({bus_addr, bus_write, bus_sel} !== {bus_q[0].addr, bus_q[0].wr, bus_q[0].sel} ||
            (bus_q[0].wr && bus_wdata !== bus_q[0].wdata)) begin
          errors++; $display("FAIL rnd_bus addr=%h wr=%b sel=%b wdata=%h exp addr=%h wr=%b sel=%b wdata=%h",
                             bus_addr, bus_write, bus_sel, bus_wdata,
                             bus_q[0].addr, bus_q[0].wr, bus_q[0].sel, bus_q[0].wdata);
        end
        if (wait_left < 0) wait_left = int'($urandom_range(0, 3));
        if (wait_left == 0) begin
          bus_ack = 1'b1; bus_rdata = bus_q[0].rdata;
          void'(bus_q.pop_front());
          wait_left = -1;
        end else begin
          wait_left--;
        end
      end
    end else if ($urandom_range(0, 7) == 0) begin
      bus_ack = 1'b1; bus_rdata = $urandom;
    end
    #1;
    if (!stall) begin
      if (gen) gen_instr();
      else bubble();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) rand_cycle(1'b1);
    for (int i = 0; i < 40; i++) rand_cycle(1'b0);
    checks++;
    if (ret_q.size() != 0 || bus_q.size() != 0) begin
      errors++; $display("FAIL rnd_drain ret_left=%0d bus_left=%0d exp 0 0", ret_q.size(), bus_q.size());
    end
    checks++;
    if (seen_faults != exp_faults) begin
      errors++; $display("FAIL rnd_faults got=%0d exp=%0d", seen_faults, exp_faults);
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load_byte();
    test_half_and_misaligned();
    test_alu();
    test_back_to_back();
    test_reset_mid_bus();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
